// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: access-size codes, LSU FSM
// state encoding and the alignment rule used by the load/store unit.
package mips_pkg;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;  // 2'b11 also decodes as a word

    typedef enum logic [1:0] {
        LsuIdle   = 2'b00,
        LsuAccess = 2'b01,
        LsuResp   = 2'b10
    } lsu_state_e;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SizeByte: ok = 1'b1;
            SizeHalf: ok = ~addr_lo[0];
            default:  ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane steering: store byte enables and replicated write data,
// and load lane extraction with sign or zero extension.
module lsu_align
    import mips_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o        = 4'b0000;
        wdata_o     = '0;
        load_data_o = '0;
        byte_sel    = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SizeByte: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            end
            SizeHalf: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            end
            default: begin
                be_o        = 4'b1111;
                wdata_o     = store_data_i;
                load_data_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one aligned access at a time, runs a
// req/ack handshake to memory and returns formatted load data.
module load_store_unit
    import mips_pkg::*;
#(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_SIZE = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [NB_SIZE-1:0] i_size,
    input  logic               i_unsigned,
    input  logic [NB_DATA-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_store_data,
    output logic               o_stall,
    output logic [NB_DATA-1:0] o_load_data,
    output logic               o_load_valid,
    output logic               o_misaligned,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NB_DATA-1:0] o_mem_addr,
    output logic [NB_DATA-1:0] o_mem_wdata,
    output logic [3:0]         o_mem_be,
    input  logic               i_mem_ack,
    input  logic [NB_DATA-1:0] i_mem_rdata
);

    lsu_state_e         state_q, state_d;
    logic [NB_DATA-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] sdata_q, sdata_d;
    logic [NB_DATA-1:0] load_data_q, load_data_d;
    logic [1:0]         size_q, size_d;
    logic               unsigned_q, unsigned_d;
    logic               we_q, we_d;
    logic               misaligned_q, misaligned_d;

    logic               one_dir;
    logic               aligned;
    logic               accept;
    logic [3:0]         lane_be;
    logic [NB_DATA-1:0] lane_wdata;
    logic [NB_DATA-1:0] load_fmt;

    // Both or neither direction strobe is a no-op, not an access.
    assign one_dir = i_valid & (i_mem_read ^ i_mem_write);
    assign aligned = is_aligned(i_size[1:0], i_addr[1:0]);
    assign accept  = (state_q == LsuIdle) & one_dir & aligned;

    lsu_align u_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .unsigned_i   (unsigned_q),
        .store_data_i (sdata_q),
        .rdata_i      (i_mem_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (load_fmt)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        load_data_d  = load_data_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        we_d         = we_q;
        misaligned_d = 1'b0;
        unique case (state_q)
            LsuIdle: begin
                misaligned_d = one_dir & ~aligned;
                if (accept) begin
                    addr_d     = i_addr;
                    sdata_d    = i_store_data;
                    size_d     = i_size[1:0];
                    unsigned_d = i_unsigned;
                    we_d       = i_mem_write;
                    state_d    = LsuAccess;
                end
            end
            LsuAccess: begin
                if (i_mem_ack) begin
                    state_d = LsuResp;
                    if (!we_q) begin
                        load_data_d = load_fmt;
                    end
                end
            end
            LsuResp: state_d = LsuIdle;
            default: state_d = LsuIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= LsuIdle;
            addr_q       <= '0;
            sdata_q      <= '0;
            load_data_q  <= '0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            we_q         <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sdata_q      <= sdata_d;
            load_data_q  <= load_data_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            we_q         <= we_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Outputs are forced low while reset is held, even before the first edge.
    always_comb begin
        o_stall      = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_be     = 4'b0000;
        o_load_valid = 1'b0;
        o_load_data  = '0;
        o_misaligned = 1'b0;
        if (!i_rst) begin
            o_stall      = accept | (state_q == LsuAccess);
            o_mem_req    = (state_q == LsuAccess);
            o_mem_we     = (state_q == LsuAccess) & we_q;
            o_mem_addr   = {addr_q[NB_DATA-1:2], 2'b00};
            o_mem_wdata  = lane_wdata;
            o_mem_be     = lane_be;
            o_load_valid = (state_q == LsuResp) & ~we_q;
            o_load_data  = load_data_q;
            o_misaligned = misaligned_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: an upstream op queue, a memory
// responder, a transaction-level model and a per-cycle compare process.
module tb_load_store_unit;

    localparam int unsigned NB_DATA = 32;
    localparam int unsigned NB_SIZE = 2;

    logic               clk = 1'b0;
    logic               i_rst;
    logic               i_valid;
    logic               i_mem_read;
    logic               i_mem_write;
    logic [NB_SIZE-1:0] i_size;
    logic               i_unsigned;
    logic [NB_DATA-1:0] i_addr;
    logic [NB_DATA-1:0] i_store_data;
    logic               o_stall;
    logic [NB_DATA-1:0] o_load_data;
    logic               o_load_valid;
    logic               o_misaligned;
    logic               o_mem_req;
    logic               o_mem_we;
    logic [NB_DATA-1:0] o_mem_addr;
    logic [NB_DATA-1:0] o_mem_wdata;
    logic [3:0]         o_mem_be;
    logic               i_mem_ack;
    logic [NB_DATA-1:0] i_mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(
        .NB_DATA (NB_DATA),
        .NB_SIZE (NB_SIZE)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_size       (i_size),
        .i_unsigned   (i_unsigned),
        .i_addr       (i_addr),
        .i_store_data (i_store_data),
        .o_stall      (o_stall),
        .o_load_data  (o_load_data),
        .o_load_valid (o_load_valid),
        .o_misaligned (o_misaligned),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_be     (o_mem_be),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          lat;    // ACCESS cycles until ack, 1 = ack in the first one
    } op_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
    } txn_t;

    op_t  ops_q[$];
    txn_t exp_q[$];
    op_t  cur_op;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    bit   first_cycle = 1'b0;
    bit   spur_ack = 1'b0;
    bit   load_due = 1'b0;
    bit   mis_due = 1'b0;
    logic [31:0] load_due_val = '0;

    int          tot_stall, tot_lv, tot_mis, tot_req, tot_hs;
    logic [31:0] last_addr, last_wdata, last_load;
    logic [3:0]  last_be;
    logic        last_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] rdata,
                               input int lat);
        op_t o;
        o.rd = rd; o.wr = wr; o.size = size; o.uns = uns;
        o.addr = addr; o.data = data; o.rdata = rdata; o.lat = lat;
        return o;
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_aligned(input op_t o);
        return (int'(o.addr[1:0]) % nbytes(o.size)) == 0;
    endfunction

    function automatic bit m_accepted(input op_t o);
        return (o.rd != o.wr) && m_aligned(o);
    endfunction

    // Expected memory transaction and load result, from byte arithmetic.
    function automatic txn_t m_txn(input op_t o);
        txn_t        t;
        int          n;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        n       = nbytes(o.size);
        off     = int'(o.addr[1:0]);
        t.we    = o.wr;
        t.addr  = o.addr & ~32'h3;
        t.be    = 4'(((1 << n) - 1) << off);
        for (int i = 0; i < 4; i++) t.wdata[8*i +: 8] = o.data[8*(i % n) +: 8];
        if (n == 4) begin
            t.load = o.rdata;
        end else begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v    = (o.rdata >> (8 * off)) & mask;
            if (!o.uns && v[8*n-1]) v = v | ~mask;
            t.load = v;
        end
        return t;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("load_valid timing", 32'(o_load_valid), 32'(load_due));
            if (o_load_valid && load_due) check("load_data", o_load_data, load_due_val);
            load_due = 1'b0;
            check("misaligned pulse", 32'(o_misaligned), 32'(mis_due));
            mis_due = 1'b0;
            if (first_cycle && i_valid && (i_mem_read != i_mem_write)) begin
                if (m_aligned(cur_op)) exp_q.push_back(m_txn(cur_op));
                else mis_due = 1'b1;
            end
            if (o_mem_req) begin
                if (exp_q.size() == 0) begin
                    check("mem_req without accepted op", 32'(o_mem_req), 32'd0);
                end else begin
                    check("mem_we", 32'(o_mem_we), 32'(exp_q[0].we));
                    check("mem_addr", o_mem_addr, exp_q[0].addr);
                    check("mem_be", 32'(o_mem_be), 32'(exp_q[0].be));
                    if (exp_q[0].we) check("mem_wdata", o_mem_wdata, exp_q[0].wdata);
                    if (i_mem_ack) begin
                        if (!exp_q[0].we) begin
                            load_due     = 1'b1;
                            load_due_val = exp_q[0].load;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Presents ops_q head-first, holding each while o_stall, answering
    // memory requests after each op's latency. Starts and ends at posedge+1.
    task automatic run_ops();
        int acc = 0;
        int tail = 0;
        int guard = 0;
        int stall_cnt = 0;
        bit stall_now;
        tot_stall = 0; tot_lv = 0; tot_mis = 0; tot_req = 0; tot_hs = 0;
        first_cycle = 1'b1;
        while ((ops_q.size() > 0 || tail < 4) && guard < 200) begin
            guard++;
            if (ops_q.size() > 0) begin
                cur_op       = ops_q[0];
                i_valid      = 1'b1;
                i_mem_read   = cur_op.rd;
                i_mem_write  = cur_op.wr;
                i_size       = cur_op.size;
                i_unsigned   = cur_op.uns;
                i_addr       = cur_op.addr;
                i_store_data = cur_op.data;
                i_mem_rdata  = cur_op.rdata;
            end else begin
                i_valid     = 1'b0;
                first_cycle = 1'b0;
                tail++;
            end
            if (o_mem_req) begin
                acc++;
                i_mem_ack = (acc >= cur_op.lat);
            end else begin
                acc       = 0;
                i_mem_ack = spur_ack;
            end
            @(negedge clk);
            stall_now = o_stall;
            if (ops_q.size() > 0) stall_cnt += int'(o_stall);
            tot_stall += int'(o_stall);
            tot_lv    += int'(o_load_valid);
            tot_mis   += int'(o_misaligned);
            tot_req   += int'(o_mem_req);
            if (o_mem_req && i_mem_ack) tot_hs++;
            if (o_mem_req) begin
                last_addr  = o_mem_addr;
                last_be    = o_mem_be;
                last_we    = o_mem_we;
                last_wdata = o_mem_wdata;
            end
            if (o_load_valid) last_load = o_load_data;
            @(posedge clk);
            #1;
            first_cycle = 1'b0;
            if (ops_q.size() > 0 && !stall_now) begin
                check("stall cycles", stall_cnt, m_accepted(ops_q[0]) ? 1 + ops_q[0].lat : 0);
                void'(ops_q.pop_front());
                stall_cnt   = 0;
                first_cycle = 1'b1;
            end
        end
        check("sequence completed", ops_q.size(), 0);
        check("accesses drained", exp_q.size(), 0);
        i_valid   = 1'b0;
        i_mem_ack = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " stall"}, 32'(o_stall), 32'd0);
        check({tag, " mem_req"}, 32'(o_mem_req), 32'd0);
        check({tag, " mem_we"}, 32'(o_mem_we), 32'd0);
        check({tag, " mem_addr"}, o_mem_addr, 32'd0);
        check({tag, " mem_wdata"}, o_mem_wdata, 32'd0);
        check({tag, " mem_be"}, 32'(o_mem_be), 32'd0);
        check({tag, " load_valid"}, 32'(o_load_valid), 32'd0);
        check({tag, " load_data"}, o_load_data, 32'd0);
        check({tag, " misaligned"}, 32'(o_misaligned), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cur_op       = mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1);
        i_rst        = 1'b1;
        i_valid      = 1'b1;
        i_mem_read   = 1'b1;
        i_mem_write  = 1'b0;
        i_size       = 2'd2;
        i_unsigned   = 1'b0;
        i_addr       = 32'h0000_0008;
        i_store_data = 32'h1234_5678;
        i_mem_ack    = 1'b0;
        i_mem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        chk_en  = 1'b1;

        // SB to lane 3, ack on the second ACCESS cycle
        ops_q.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'hA5, 32'h0, 2));
        run_ops();
        check("SB be", 32'(last_be), 32'h8);
        check("SB wdata", last_wdata, 32'hA5A5_A5A5);
        check("SB addr", last_addr, 32'h10);
        check("SB we", 32'(last_we), 32'd1);
        check("SB stall cycles", tot_stall, 3);
        check("SB no load_valid", tot_lv, 0);

        ops_q.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h2, 32'h0, 32'h0080_FF00, 1));
        run_ops();
        check("LB data", last_load, 32'hFFFF_FF80);
        check("LB be", 32'(last_be), 32'h4);
        check("LB we", 32'(last_we), 32'd0);

        ops_q.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h2, 32'h0, 32'h0080_FF00, 1));
        run_ops();
        check("LBU data", last_load, 32'h0000_0080);

        ops_q.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'h8001_1234, 1));
        run_ops();
        check("LH data", last_load, 32'hFFFF_8001);
        check("LH be", 32'(last_be), 32'hC);

        ops_q.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'hCAFE_F00D, 1));
        run_ops();
        check("LW load_valid cycles", tot_lv, 1);
        check("LW data", last_load, 32'hCAFE_F00D);
        check("LW stall cycles", tot_stall, 2);

        // Misaligned word with a stray ack that must be ignored
        spur_ack = 1'b1;
        ops_q.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h5555_5555, 1));
        run_ops();
        spur_ack = 1'b0;
        check("LW misaligned pulses", tot_mis, 1);
        check("LW misaligned req cycles", tot_req, 0);
        check("LW misaligned stall", tot_stall, 0);
        check("LW misaligned load_valid", tot_lv, 0);

        ops_q.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234_ABCD, 32'h0, 3));
        ops_q.push_back(mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 32'h0000_F00F, 1));
        ops_q.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 1));
        ops_q.push_back(mk(1'b1, 1'b1, 2'd2, 1'b0, 32'h304, 32'h0, 32'h0, 1));
        ops_q.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h7777, 32'h0, 1));
        ops_q.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 32'h80FF_0000, 2));
        ops_q.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 32'h40C, 32'h0BAD_BEEF, 32'h0, 1));
        run_ops();
        check("mixed handshakes", tot_hs, 4);
        check("mixed misaligned pulses", tot_mis, 1);
        check("mixed last load", last_load, 32'h0000_0080);

        // LW then SW back to back: each accepted exactly once
        ops_q.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h1122_3344, 1));
        ops_q.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h44, 32'h99, 32'h0, 2));
        run_ops();
        check("b2b handshakes", tot_hs, 2);
        check("b2b req cycles", tot_req, 3);
        check("b2b last addr", last_addr, 32'h44);
        check("b2b load data held", o_load_data, 32'h1122_3344);

        // Reset while a store is in ACCESS; ack arrives afterwards
        chk_en       = 1'b0;
        i_valid      = 1'b1;
        i_mem_read   = 1'b0;
        i_mem_write  = 1'b1;
        i_size       = 2'd2;
        i_addr       = 32'h20;
        i_store_data = 32'h55;
        i_mem_ack    = 1'b0;
        @(negedge clk);
        check("abort accept stall", 32'(o_stall), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort in access", 32'(o_mem_req), 32'd1);
        @(posedge clk);
        #1;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        check_outputs_zero("abort reset");
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_mem_ack = (k == 1);
            @(negedge clk);
            check("abort mem_req", 32'(o_mem_req), 32'd0);
            check("abort stall", 32'(o_stall), 32'd0);
            check("abort load_valid", 32'(o_load_valid), 32'd0);
            check("abort load_data", o_load_data, 32'd0);
            @(posedge clk);
            #1;
        end
        i_mem_ack = 1'b0;
        exp_q.delete();
        load_due = 1'b0;
        mis_due  = 1'b0;
        chk_en   = 1'b1;

        ops_q.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hA1B2_C3D4, 1));
        run_ops();
        check("recovery handshakes", tot_hs, 1);
        check("recovery load", last_load, 32'hA1B2_C3D4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, datapath width; only 32 is supported (4 byte lanes).
REQ-002 SHALL have parameter NB_SIZE, default 2, width of access-size code.
REQ-003 SHALL have ports: i_clk in 1 clock; i_rst in 1 reset, one clock, synchronous, active-high.
REQ-004 SHALL have inputs: i_valid 1, MEM-stage instruction valid; i_mem_read 1, load; i_mem_write 1, store; i_size NB_SIZE (00 byte, 01 half, 10/11 word); i_unsigned 1 (LBU/LHU zero-extend); i_addr NB_DATA, ALU result used as byte address; i_store_data NB_DATA, rt value.
REQ-005 SHALL have pipeline outputs: o_stall 1, hold upstream stages; o_load_data NB_DATA, formatted load result; o_load_valid 1, load result strobe; o_misaligned 1, alignment-fault pulse.
REQ-006 SHALL have memory ports: o_mem_req 1; o_mem_we 1; o_mem_addr NB_DATA (word-aligned, bits[1:0]=00); o_mem_wdata NB_DATA; o_mem_be 4; i_mem_ack 1; i_mem_rdata NB_DATA.

Function
REQ-007 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-008 In IDLE, a request is accepted when i_valid and exactly one of i_mem_read/i_mem_write is high and the address is aligned; both high, or neither, is a no-op.
REQ-009 Alignment: byte always aligned; half requires i_addr[0]=0; word requires i_addr[1:0]=00.
REQ-010 Misaligned valid access: no memory request, no stall, o_misaligned high exactly one cycle after the input cycle.
REQ-011 On accept: capture addr/size/unsigned/store data/direction; IDLE->ACCESS.
REQ-012 In ACCESS: o_mem_req=1, all o_mem_* held stable until i_mem_ack sampled high; then ->RESP.
REQ-013 o_stall SHALL equal (IDLE and accepting) or ACCESS; low in RESP and idle.
REQ-014 In RESP: no new request accepted; next state IDLE unconditionally.
REQ-015 Minimum latency: accept cycle + 1 ACCESS cycle (ack same cycle) + RESP; o_load_valid high one cycle, in RESP, loads only.
REQ-016 Store lanes, little-endian: byte be=1<<addr[1:0], wdata={4{d[7:0]}}; half be=addr[1]?1100:0011, wdata={2{d[15:0]}}; word be=1111, wdata=d.
REQ-017 Loads SHALL drive o_mem_be with the accessed lanes; o_mem_we=0.
REQ-018 Load format: select lane(s) by addr, sign-extend unless i_unsigned; word passes i_mem_rdata; o_load_data registered on ack and held until next load ack.
REQ-019 i_mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-020 While i_rst: state IDLE; o_stall, o_mem_req, o_mem_we, o_load_valid, o_misaligned = 0; o_mem_addr, o_mem_wdata, o_mem_be, o_load_data = 0.
REQ-021 Reset during ACCESS SHALL abort: o_mem_req low the cycle after reset is sampled; a later ack is ignored.

Structure
REQ-022 Size codes (BYTE/HALF/WORD) and FSM state encodings SHALL live in shared package mips_pkg.
REQ-023 Lane steering SHALL be one combinational sub-module lsu_align (store be/wdata, load extract/extend); FSM and registers in load_store_unit.

Verification
REQ-024 SB addr=0x00000013, data=0x000000A5, ack after 2 cycles -> be=1000, wdata=0xA5A5A5A5, addr=0x00000010, o_stall high 3 cycles.
REQ-025 LB addr=0x00000002, rdata=0x0080FF00, i_unsigned=0 -> o_load_data=0xFFFFFF80; repeat i_unsigned=1 -> 0x00000080.
REQ-026 LH addr=0x00000002, rdata=0x8001_1234 -> 0xFFFF8001; LW addr=0x00000004 ack same cycle -> o_load_valid exactly one cycle, data=rdata.
REQ-027 LW addr=0x00000006 -> o_misaligned one pulse, o_mem_req never high, o_stall low.
REQ-028 SW accepted, i_rst asserted in ACCESS, ack 2 cycles later -> o_mem_req low after reset, no RESP, state IDLE, outputs zero.
REQ-029 Back-to-back LW then SW held in input -> second access accepted only after RESP, never re-accepting the first.
